load_data_queue: RTL and testbench
==================================

// Module: load_data_queue
// PURPOSE
//  Multi-entry successor to the single-slot load data stage. It accepts address-resolved loads and merges
//  store-queue forwarded bytes with cache hit bytes. Cache misses are parked on their MSHR index instead of
//  back-pressuring, and complete on the fill broadcast. Finished loads go out to the load buffer.
//  Sits between load address stage and load buffer/CDB; honours branch-mask resolve/squash.
// PARAMETERS
//  DEPTH       4   in-flight load entries
//  WORD_BYTES  4   bytes per data word (power of 2)
//  BLOCK_WORDS 2   words per cache block (power of 2)
//  ADDR_W      32  address width
//  BM_W        4   branch mask width
//  TAG_W       6   destination physical register index width
//  MSHR_W      3   MSHR index width
//  SQ_W        3   store queue pointer width
//  FUNC_W      3   load function code width
// PORTS
//  clock           in   1                  system clock
//  reset           in   1                  asynchronous, active-low (0 = reset)
//  in_valid        in   1                  load offered from address stage
//  in_ready        out  1                  a FREE entry exists
//  in_addr         in   ADDR_W             load address
//  in_byte_mask    in   WORD_BYTES         bytes requested within word
//  in_bm/in_dest/in_func/in_sq_tail  in  BM_W/TAG_W/FUNC_W/SQ_W  load metadata
//  sq_addr/sq_tail out  ADDR_W/SQ_W        forwarding lookup (= in_addr/in_sq_tail)
//  sq_data/sq_mask in   8*WORD_BYTES/WORD_BYTES  forwarded bytes and valid mask, same cycle
//  cache_req_valid out  1                  cache lookup request
//  cache_req_addr  out  ADDR_W             lookup address
//  cache_hit       in   1                  lookup hit, same cycle
//  cache_data      in   8*WORD_BYTES*BLOCK_WORDS  hit block data
//  cache_mshr_ok   in   1                  miss accepted; cache_mshr_idx valid
//  cache_mshr_idx  in   MSHR_W             MSHR tracking the miss
//  fill_valid/fill_mshr_idx/fill_data in 1/MSHR_W/8*WORD_BYTES*BLOCK_WORDS  miss fill broadcast
//  out_valid       out  1                  completed load presented
//  out_ready       in   1                  load buffer accepts
//  out_data/out_dest/out_func/out_addr/out_bm out  raw merged word + metadata (bm already resolve-cleared)
//  b_resolve       in   BM_W               one-hot resolving branch
//  b_mispred       in   1                  resolving branch mispredicted
// BEHAVIOUR
//  Entry state: FREE, RETRY, WAIT_FILL, DONE. Reset forces all FREE: in_ready=1, out_valid=0, cache_req_valid=0.
//  w_idx = addr[$clog2(WORD_BYTES) +: $clog2(BLOCK_WORDS)]; byte i of word = data[w_idx*WORD_BYTES+i].
//  in_ready = any FREE entry at start of cycle. Slots freed this cycle are reusable next cycle.
//  Allocation (in_valid&&in_ready) takes the lowest-index FREE entry. The cache port drives in_addr the same cycle.
//  Per requested byte, priority is sq_mask > cache_hit > matching same-cycle fill.
//    all bytes covered -> DONE; else cache_mshr_ok -> WAIT_FILL(idx); else -> RETRY.
//  RETRY: if no allocation this cycle, the lowest-index RETRY entry gets the cache port.
//    Hit covering all missing bytes -> DONE; mshr_ok -> WAIT_FILL; else stays RETRY. SQ is not re-queried.
//  Fill: every WAIT_FILL entry with matching mshr_idx takes its still-missing bytes from fill_data and goes DONE.
//  Output: lowest-index DONE entry drives out_*. Handshake out_valid&&out_ready -> entry FREE at next edge.
//    out_* is held stable while out_valid&&!out_ready, unless squashed.
//  Branch: (b_resolve&bm)!=0 && b_mispred -> entry FREE next edge. The same-cycle incoming load is not allocated.
//    out_valid is combinationally masked for a squashed entry. Squash beats fill, retry and dequeue.
//  Correct resolve clears the bit in every entry's bm and in the allocating load. out_bm shows the cleared mask.
//  Unrequested bytes of out_data are 0. No sign/zero extension here (downstream uses out_func).
//  Reset mid-operation: all entries drop immediately (async), no output or request glitch after assertion.
// TESTING
//  Hit: addr=0x104,mask=4'hF,cache_hit,data word1=0xDEADBEEF -> out_valid next cycle, out_data=0xDEADBEEF.
//  Forward merge: sq_mask=4'b0011 sq=0x????1122, hit word=0xAABBCCDD -> out_data=0xAABB1122.
//  Miss: mshr_ok idx=2; fill idx=2 three cycles later -> DONE on fill edge, out_valid next cycle.
//  Fill all four entries (misses) -> in_ready=0; one fill -> in_ready=1 a cycle after that entry's dequeue.
//  Squash: entries bm=4'b0010/4'b0001, b_resolve=4'b0010 mispred -> first FREE. Second resolve correct -> out_bm=0.
//  Retry: no hit, mshr_ok=0 -> RETRY; with in_valid=0, re-request at same addr; hit -> DONE.

Source files
------------

// File: rtl/load_data_queue.sv
// Multi-entry load data queue: merges store-forwarded and cache bytes, parks misses on their MSHR
// until the fill broadcast, and drains completed loads in index order to the load buffer.
module load_data_queue #(
  parameter int DEPTH       = 4,
  parameter int WORD_BYTES  = 4,
  parameter int BLOCK_WORDS = 2,
  parameter int ADDR_W      = 32,
  parameter int BM_W        = 4,
  parameter int TAG_W       = 6,
  parameter int MSHR_W      = 3,
  parameter int SQ_W        = 3,
  parameter int FUNC_W      = 3
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [ADDR_W-1:0]                 in_addr,
  input  logic [WORD_BYTES-1:0]             in_byte_mask,
  input  logic [BM_W-1:0]                   in_bm,
  input  logic [TAG_W-1:0]                  in_dest,
  input  logic [FUNC_W-1:0]                 in_func,
  input  logic [SQ_W-1:0]                   in_sq_tail,
  output logic [ADDR_W-1:0]                 sq_addr,
  output logic [SQ_W-1:0]                   sq_tail,
  input  logic [8*WORD_BYTES-1:0]           sq_data,
  input  logic [WORD_BYTES-1:0]             sq_mask,
  output logic                              cache_req_valid,
  output logic [ADDR_W-1:0]                 cache_req_addr,
  input  logic                              cache_hit,
  input  logic [8*WORD_BYTES*BLOCK_WORDS-1:0] cache_data,
  input  logic                              cache_mshr_ok,
  input  logic [MSHR_W-1:0]                 cache_mshr_idx,
  input  logic                              fill_valid,
  input  logic [MSHR_W-1:0]                 fill_mshr_idx,
  input  logic [8*WORD_BYTES*BLOCK_WORDS-1:0] fill_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [8*WORD_BYTES-1:0]           out_data,
  output logic [TAG_W-1:0]                  out_dest,
  output logic [FUNC_W-1:0]                 out_func,
  output logic [ADDR_W-1:0]                 out_addr,
  output logic [BM_W-1:0]                   out_bm,
  input  logic [BM_W-1:0]                   b_resolve,
  input  logic                              b_mispred
);

  localparam int WORD_W  = 8 * WORD_BYTES;
  localparam int BLOCK_W = WORD_W * BLOCK_WORDS;
  localparam int OFF_W   = $clog2(WORD_BYTES);
  localparam int WSEL_W  = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_FREE, S_RETRY, S_WAIT_FILL, S_DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]     addr;
    logic [WORD_BYTES-1:0] req;
    logic [WORD_BYTES-1:0] have;
    logic [WORD_W-1:0]     data;
    logic [BM_W-1:0]       bm;
    logic [TAG_W-1:0]      dest;
    logic [FUNC_W-1:0]     func;
    logic [MSHR_W-1:0]     mshr;
  } entry_t;

  function automatic logic [IDX_W-1:0] first_set(input logic [DEPTH-1:0] v);
    first_set = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (v[i]) first_set = IDX_W'(i);
    end
  endfunction

  function automatic logic [WORD_W-1:0] merge_bytes(input logic [WORD_W-1:0] base,
                                                    input logic [WORD_BYTES-1:0] sel,
                                                    input logic [WORD_W-1:0] src);
    merge_bytes = base;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (sel[b]) merge_bytes[b*8 +: 8] = src[b*8 +: 8];
    end
  endfunction

  function automatic logic [WORD_W-1:0] word_of(input logic [BLOCK_W-1:0] blk,
                                                input logic [ADDR_W-1:0] a);
    int w;
    w = 0;
    if (BLOCK_WORDS > 1) w = int'(a[OFF_W +: WSEL_W]);
    word_of = blk[w*WORD_W +: WORD_W];
  endfunction

  state_t state_q [DEPTH];
  state_t state_d [DEPTH];
  entry_t ent_q   [DEPTH];
  entry_t ent_d   [DEPTH];

  logic [DEPTH-1:0] free_v, retry_v, done_v, kill_v;
  logic [IDX_W-1:0] alloc_idx, retry_idx, out_idx;
  logic             in_kill, alloc_go, retry_go, out_fire;
  logic             hold_q, hold_ok;
  logic [IDX_W-1:0] hold_idx_q;
  entry_t           alloc_ent;
  state_t           alloc_state;
  logic             fill_same;

  // Squashed entries are hidden from every selector so a squash wins over retry, fill and dequeue.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      kill_v[i]  = b_mispred && (state_q[i] != S_FREE) && ((b_resolve & ent_q[i].bm) != '0);
      free_v[i]  = (state_q[i] == S_FREE);
      retry_v[i] = (state_q[i] == S_RETRY) && !kill_v[i];
      done_v[i]  = (state_q[i] == S_DONE) && !kill_v[i];
    end
  end

  assign alloc_idx = first_set(free_v);
  assign retry_idx = first_set(retry_v);
  assign in_ready  = |free_v;
  assign in_kill   = b_mispred && ((b_resolve & in_bm) != '0);
  // Gating with reset keeps the cache port quiet while reset is asserted.
  assign alloc_go  = reset && in_valid && in_ready && !in_kill;
  assign retry_go  = reset && !alloc_go && (|retry_v);

  assign sq_addr         = in_addr;
  assign sq_tail         = in_sq_tail;
  assign cache_req_valid = alloc_go || retry_go;
  assign cache_req_addr  = alloc_go ? in_addr : (retry_go ? ent_q[retry_idx].addr : in_addr);

  assign hold_ok   = hold_q && done_v[hold_idx_q];
  assign out_idx   = hold_ok ? hold_idx_q : first_set(done_v);
  assign out_valid = hold_ok || (|done_v);
  assign out_fire  = out_valid && out_ready;
  assign out_data  = ent_q[out_idx].data;
  assign out_dest  = ent_q[out_idx].dest;
  assign out_func  = ent_q[out_idx].func;
  assign out_addr  = ent_q[out_idx].addr;
  assign out_bm    = ent_q[out_idx].bm & ~b_resolve;

  // Incoming load: forwarded bytes first, then a cache hit, then a fill landing on the MSHR just granted.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    alloc_ent      = '0;
    alloc_ent.addr = in_addr;
    alloc_ent.req  = in_byte_mask;
    alloc_ent.bm   = in_bm & ~b_resolve;
    alloc_ent.dest = in_dest;
    alloc_ent.func = in_func;
    alloc_ent.mshr = cache_mshr_idx;
    alloc_ent.data = merge_bytes('0, in_byte_mask & sq_mask, sq_data);
    alloc_ent.have = in_byte_mask & sq_mask;
    fill_same      = fill_valid && cache_mshr_ok && (fill_mshr_idx == cache_mshr_idx);
    if (cache_hit) begin
      alloc_ent.data = merge_bytes(alloc_ent.data, in_byte_mask & ~sq_mask,
                                   word_of(cache_data, in_addr));
      alloc_ent.have = in_byte_mask;
    end else if (fill_same) begin
      alloc_ent.data = merge_bytes(alloc_ent.data, in_byte_mask & ~sq_mask,
                                   word_of(fill_data, in_addr));
      alloc_ent.have = in_byte_mask;
    end
    if (alloc_ent.have == in_byte_mask) alloc_state = S_DONE;
    else if (cache_mshr_ok)             alloc_state = S_WAIT_FILL;
    else                                alloc_state = S_RETRY;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      state_d[i]    = state_q[i];
      ent_d[i]      = ent_q[i];
      ent_d[i].bm   = ent_q[i].bm & ~b_resolve;
      if (kill_v[i]) begin
        state_d[i] = S_FREE;
      end else if (out_fire && (out_idx == IDX_W'(i))) begin
        state_d[i] = S_FREE;
      end else if (alloc_go && (alloc_idx == IDX_W'(i))) begin
        state_d[i] = alloc_state;
        ent_d[i]   = alloc_ent;
      end else if (retry_go && (retry_idx == IDX_W'(i))) begin
        if (cache_hit) begin
          ent_d[i].data = merge_bytes(ent_q[i].data, ent_q[i].req & ~ent_q[i].have,
                                      word_of(cache_data, ent_q[i].addr));
          ent_d[i].have = ent_q[i].req;
          state_d[i]    = S_DONE;
        end else if (cache_mshr_ok) begin
          ent_d[i].mshr = cache_mshr_idx;
          state_d[i]    = S_WAIT_FILL;
        end
      end else if ((state_q[i] == S_WAIT_FILL) && fill_valid && (ent_q[i].mshr == fill_mshr_idx)) begin
        ent_d[i].data = merge_bytes(ent_q[i].data, ent_q[i].req & ~ent_q[i].have,
                                    word_of(fill_data, ent_q[i].addr));
        ent_d[i].have = ent_q[i].req;
        state_d[i]    = S_DONE;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every entry updates from the same pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= S_FREE;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= state_d[i];
      hold_q     <= out_valid && !out_ready;
      hold_idx_q <= out_idx;
    end
  end

  // NOTE: payload storage is not reset; a FREE state makes its contents irrelevant.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
  end

endmodule

// File: tb/tb_load_data_queue.sv
// Directed bench for load_data_queue: stimulus pushes expected loads into a scoreboard that a
// negedge monitor pops on every output handshake.
module tb_load_data_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [3:0]  in_byte_mask;
  logic [3:0]  in_bm;
  logic [5:0]  in_dest;
  logic [2:0]  in_func;
  logic [2:0]  in_sq_tail;
  logic [31:0] sq_addr;
  logic [2:0]  sq_tail;
  logic [31:0] sq_data;
  logic [3:0]  sq_mask;
  logic        cache_req_valid;
  logic [31:0] cache_req_addr;
  logic        cache_hit;
  logic [63:0] cache_data;
  logic        cache_mshr_ok;
  logic [2:0]  cache_mshr_idx;
  logic        fill_valid;
  logic [2:0]  fill_mshr_idx;
  logic [63:0] fill_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_dest;
  logic [2:0]  out_func;
  logic [31:0] out_addr;
  logic [3:0]  out_bm;
  logic [3:0]  b_resolve;
  logic        b_mispred;

  load_data_queue dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_byte_mask(in_byte_mask),
    .in_bm(in_bm), .in_dest(in_dest), .in_func(in_func), .in_sq_tail(in_sq_tail),
    .sq_addr(sq_addr), .sq_tail(sq_tail), .sq_data(sq_data), .sq_mask(sq_mask),
    .cache_req_valid(cache_req_valid), .cache_req_addr(cache_req_addr), .cache_hit(cache_hit),
    .cache_data(cache_data), .cache_mshr_ok(cache_mshr_ok), .cache_mshr_idx(cache_mshr_idx),
    .fill_valid(fill_valid), .fill_mshr_idx(fill_mshr_idx), .fill_data(fill_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_dest(out_dest),
    .out_func(out_func), .out_addr(out_addr), .out_bm(out_bm),
    .b_resolve(b_resolve), .b_mispred(b_mispred)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  dest;
    logic [2:0]  func;
    logic [31:0] addr;
    logic [3:0]  bm;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [5:0] dst, input logic [2:0] f,
                      input logic [31:0] a, input logic [3:0] m);
    exp_t e;
    e.data = d; e.dest = dst; e.func = f; e.addr = a; e.bm = m;
    exp_q.push_back(e);
  endtask

  always @(negedge clock) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got dest=%0h data=%0h expected no output", out_dest, out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_data", 64'(out_data), 64'(e.data));
        check("out_dest", 64'(out_dest), 64'(e.dest));
        check("out_func", 64'(out_func), 64'(e.func));
        check("out_addr", 64'(out_addr), 64'(e.addr));
        check("out_bm",   64'(out_bm),   64'(e.bm));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_addr = '0; in_byte_mask = '0; in_bm = '0; in_dest = '0; in_func = '0;
    in_sq_tail = '0; sq_data = '0; sq_mask = '0; cache_hit = 0; cache_data = '0;
    cache_mshr_ok = 0; cache_mshr_idx = '0; fill_valid = 0; fill_mshr_idx = '0; fill_data = '0;
    b_resolve = '0; b_mispred = 0;
  endtask

  task automatic load(input logic [31:0] a, input logic [3:0] m, input logic [3:0] bm,
                      input logic [5:0] dst, input logic [2:0] f);
    in_valid = 1; in_addr = a; in_byte_mask = m; in_bm = bm; in_dest = dst; in_func = f;
    in_sq_tail = 3'd1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    out_ready = 1;
    reset = 0;
    in_valid = 1;
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_cache_req", 64'(cache_req_valid), 64'd0);
    in_valid = 0;
    #10 reset = 1;
    step();

    // Plain hit on word 1
    load(32'h104, 4'hF, 4'h0, 6'd5, 3'd2);
    cache_hit = 1; cache_data = {32'hDEADBEEF, 32'h11111111};
    #1;
    check("hit_req_valid", 64'(cache_req_valid), 64'd1);
    check("hit_req_addr", 64'(cache_req_addr), 64'h104);
    check("hit_sq_addr", 64'(sq_addr), 64'h104);
    push(32'hDEADBEEF, 6'd5, 3'd2, 32'h104, 4'h0);
    step(); idle();
    check("hit_out_valid", 64'(out_valid), 64'd1);
    step();
    check("hit_drained", 64'(out_valid), 64'd0);

    // Forward merge; a correct resolve clears the bit in the allocating load
    load(32'h100, 4'hF, 4'b0100, 6'd6, 3'd3);
    sq_mask = 4'b0011; sq_data = 32'h99991122;
    cache_hit = 1; cache_data = {32'h0, 32'hAABBCCDD};
    b_resolve = 4'b0100;
    push(32'hAABB1122, 6'd6, 3'd3, 32'h100, 4'h0);
    step();
    // Partial byte mask: unrequested bytes come back zero
    idle();
    load(32'h108, 4'b0110, 4'h0, 6'd7, 3'd1);
    cache_hit = 1; cache_data = {32'hFFFFFFFF, 32'h12345678};
    push(32'h00345600, 6'd7, 3'd1, 32'h108, 4'h0);
    step(); idle(); step(); step();

    // Miss parked on MSHR 2, forwarded upper bytes, unrelated fill ignored
    load(32'h200, 4'hF, 4'h0, 6'd9, 3'd4);
    sq_mask = 4'b1100; sq_data = 32'h55660000;
    cache_mshr_ok = 1; cache_mshr_idx = 3'd2;
    step(); idle();
    check("miss_no_out", 64'(out_valid), 64'd0);
    step();
    fill_valid = 1; fill_mshr_idx = 3'd3; fill_data = {32'h0, 32'h77777777};
    step();
    check("miss_wrong_fill", 64'(out_valid), 64'd0);
    fill_mshr_idx = 3'd2; fill_data = {32'h0, 32'hAAAAF00D};
    push(32'h5566F00D, 6'd9, 3'd4, 32'h200, 4'h0);
    step(); idle();
    check("fill_out_valid", 64'(out_valid), 64'd1);
    step();
    check("fill_drained", 64'(out_valid), 64'd0);

    // Fill all four entries with misses
    for (int k = 0; k < 4; k++) begin
      load(32'h300 + 32'(k * 16), 4'hF, 4'h0, 6'(10 + k), 3'(k));
      cache_mshr_ok = 1;
      cache_mshr_idx = (k == 0) ? 3'd0 : (k == 1) ? 3'd1 : (k == 2) ? 3'd3 : 3'd4;
      step();
    end
    idle();
    load(32'h700, 4'hF, 4'h0, 6'd30, 3'd0);
    cache_hit = 1;
    #1;
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_no_req", 64'(cache_req_valid), 64'd0);
    step(); idle();
    fill_valid = 1; fill_mshr_idx = 3'd1; fill_data = {32'h0, 32'h00001001};
    push(32'h00001001, 6'd11, 3'd1, 32'h310, 4'h0);
    step(); idle();
    check("done_not_free", 64'(in_ready), 64'd0);
    check("full_out_valid", 64'(out_valid), 64'd1);
    step();
    check("freed_in_ready", 64'(in_ready), 64'd1);
    fill_valid = 1; fill_mshr_idx = 3'd0; fill_data = {32'h0, 32'h00001000};
    push(32'h00001000, 6'd10, 3'd0, 32'h300, 4'h0);
    step();
    fill_mshr_idx = 3'd3; fill_data = {32'h0, 32'h00001002};
    push(32'h00001002, 6'd12, 3'd2, 32'h320, 4'h0);
    step();
    fill_mshr_idx = 3'd4; fill_data = {32'h0, 32'h00001003};
    push(32'h00001003, 6'd13, 3'd3, 32'h330, 4'h0);
    step(); idle();
    step(); step(); step();
    check("drain_all", 64'(out_valid), 64'd0);

    // Hold under back-pressure, then squash the held entry
    out_ready = 0;
    load(32'h500, 4'hF, 4'b0010, 6'd7, 3'd5);
    cache_hit = 1; cache_data = {32'h0, 32'h11112222};
    step();
    load(32'h504, 4'hF, 4'b0001, 6'd8, 3'd6);
    cache_hit = 1; cache_data = {32'h33334444, 32'h0};
    step(); idle();
    check("hold_dest", 64'(out_dest), 64'd7);
    step();
    check("hold_stable", 64'(out_dest), 64'd7);
    load(32'h600, 4'hF, 4'b0010, 6'd31, 3'd0);
    cache_hit = 1;
    b_resolve = 4'b0010; b_mispred = 1;
    #1;
    check("squash_masks_out", 64'(out_dest), 64'd8);
    check("squash_no_req", 64'(cache_req_valid), 64'd0);
    step(); idle();
    b_resolve = 4'b0001;
    #1;
    check("resolve_out_bm_comb", 64'(out_bm), 64'd0);
    step(); idle();
    check("resolve_out_bm_reg", 64'(out_bm), 64'd0);
    push(32'h33334444, 6'd8, 3'd6, 32'h504, 4'h0);
    out_ready = 1;
    step(); step();
    check("squash_drained", 64'(out_valid), 64'd0);

    // Retry: no hit and no MSHR, then a later hit fills the missing bytes
    load(32'h404, 4'hF, 4'h0, 6'd20, 3'd7);
    sq_mask = 4'b0001; sq_data = 32'h000000EE;
    step(); idle();
    #1;
    check("retry_req_valid", 64'(cache_req_valid), 64'd1);
    check("retry_req_addr", 64'(cache_req_addr), 64'h404);
    check("retry_no_out", 64'(out_valid), 64'd0);
    step();
    cache_hit = 1; cache_data = {32'h0BADCAFE, 32'h0};
    push(32'h0BADCAEE, 6'd20, 3'd7, 32'h404, 4'h0);
    step(); idle();
    check("retry_done", 64'(out_valid), 64'd1);
    step();

    // Asynchronous reset mid-operation
    out_ready = 0;
    load(32'h800, 4'hF, 4'h0, 6'd21, 3'd0);
    cache_hit = 1;
    step(); idle();
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    in_valid = 1;
    #2 reset = 0;
    #1;
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_in_ready", 64'(in_ready), 64'd1);
    check("async_no_req", 64'(cache_req_valid), 64'd0);
    idle();
    #3 reset = 1;
    out_ready = 1;
    step(); step();
    check("post_reset_quiet", 64'(out_valid), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
